mccu_irq_ctrl: RTL
==================

Name: mccu_irq_ctrl

Overview:
- Sits directly downstream of the MCCU quota monitor. It consumes the per-core quota interrupt and the internal quota value, and drives the per-core quota/update inputs back into the MCCU.
- Per core, it turns the combinational quota-exceeded level into a sticky, maskable, acknowledgeable pending interrupt.
- It optionally reloads the core's quota on acknowledge.
- It counts quota-exceeded events that arrive while one is still pending (overruns).

Parameters:
- N_CORES, 2, number of monitored cores; must match the MCCU instance.
- DATA_WIDTH, 32, quota width; must match the MCCU instance.
- CNT_WIDTH, 8, width of each per-core overrun counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  block enable; the same signal drives the MCCU enable.
- irq_quota_i  in  [N_CORES]  MCCU per-core quota-exceeded level.
- mask_i  in  [N_CORES]  1 = core's pending state does not reach irq_o.
- ack_i  in  [N_CORES]  software acknowledge, one-cycle pulse.
- auto_reload_i  in  [N_CORES]  1 = reload quota on acknowledge.
- reload_value_i  in  [N_CORES][DATA_WIDTH]  quota loaded on reload.
- update_quota_o  out  [N_CORES]  one-cycle pulse to MCCU update_quota_i.
- quota_o  out  [N_CORES][DATA_WIDTH]  value to MCCU quota_i, registered.
- pending_o  out  [N_CORES]  sticky pending flag per core.
- overrun_cnt_o  out  [N_CORES][CNT_WIDTH]  saturating overrun count.
- irq_o  out  1  OR over all cores of (pending_o & ~mask_i), registered.

Behaviour:
- Reset (rst_i=1, asynchronous, any cycle including mid-operation):
  - all per-core FSMs go to IDLE;
  - irq_q edge register, pending_o, update_quota_o, quota_o, overrun_cnt_o and irq_o all read 0.
- Edge detect: rise[i] = irq_quota_i[i] & ~irq_q[i] & enable_i. irq_q is registered every cycle regardless of state.
- Per-core FSM, with states IDLE, PENDING, RELOAD, HOLDOFF:
  - IDLE: on rise[i], go to PENDING. pending_o rises the cycle after the rise (1-cycle latency).
  - PENDING: pending_o=1.
    - ack_i[i] & auto_reload_i[i]: go to RELOAD.
    - ack_i[i] & ~auto_reload_i[i]: go to HOLDOFF.
    - Otherwise stay in PENDING.
  - RELOAD: exactly one cycle.
    - update_quota_o[i]=1 and quota_o[i]=reload_value_i[i], both sampled on the ack cycle; pending_o=0.
    - Then go to HOLDOFF.
  - HOLDOFF: pending_o=0.
    - Stay while irq_quota_i[i]=1. The MCCU level can lag an update by one cycle; holdoff must not re-trigger on it.
    - Go to IDLE when irq_quota_i[i]=0.
- Timing from ack:
  - pending_o falls on the cycle after ack (M+1).
  - With reload, update_quota_o pulses on M+1.
- Overrun counter:
  - Increments on rise[i] while in PENDING.
  - Saturates at all-ones.
  - Cleared only by reset.
- Simultaneous rise[i] and ack_i[i] in PENDING: the ack transition is taken and the overrun increments.
- ack_i in any state other than PENDING: ignored.
- enable_i=0: rise is suppressed, so there are no new pendings. Existing PENDING states are held, and ack is still accepted.
- irq_o is registered from next-state pending and mask, so irq_o rises together with pending_o. mask_i changes reach irq_o in 1 cycle.
- quota_o holds its last loaded value between reloads. update_quota_o is 0 outside RELOAD.

Optional Feature:
- Macro MCCU_IRQ_TIMESTAMP_EN.
- When defined:
  - a free-running DATA_WIDTH cycle counter is added, reset to 0 and wrapping at all-ones;
  - an output port ts_o [N_CORES][DATA_WIDTH] is added;
  - ts_o[i] captures the counter value on the cycle rise[i] moves IDLE to PENDING, and holds until the next such capture;
  - overrun rises do not update ts_o.
- When undefined: the counter and ts_o are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst_i=1 pulse mid-PENDING -> pending_o, irq_o, overrun_cnt_o, quota_o all 0 asynchronously. After release, irq_quota_i held 0 -> nothing changes.
- Basic pending, mask=0: irq_quota_i[0] rises at cycle 10 -> pending_o[0]=1 and irq_o=1 at cycle 11. mask_i[0]=1 at cycle 15 -> irq_o=0 at cycle 16 while pending_o[0] stays 1.
- Reload: auto_reload_i[0]=1, reload_value_i[0]=1000, ack at cycle 20 -> update_quota_o[0] pulses once at cycle 21 with quota_o[0]=1000. irq_quota_i held high to cycle 22 -> no new pending. irq_quota_i re-rises at cycle 25 -> pending at cycle 26.
- Overrun: while PENDING, irq_quota_i[1] toggles 1/0 three times -> overrun_cnt_o[1]=3. With CNT_WIDTH=2 and five toggles -> saturates at 3.
- Simultaneous: rise and ack in the same cycle with auto_reload_i=0 -> pending_o falls next cycle, overrun +1, no update pulse. With enable_i=0, a rise -> no pending.
- MCCU_IRQ_TIMESTAMP_EN defined: rise at counter value 37 -> ts_o[0]=37. A subsequent overrun rise leaves ts_o[0]=37.

Source files
------------

// File: rtl/mccu_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mccu_irq_ctrl_if
// Bundles the signals between the MCCU quota interrupt controller and its
// environment (software and the MCCU itself).
//
// Signals:
//   enable_i        block enable (also drives the MCCU enable)
//   irq_quota_i     MCCU per-core quota-exceeded level
//   mask_i          per-core mask; 1 keeps that core's pending state off irq_o
//   ack_i           per-core software acknowledge pulse
//   auto_reload_i   per-core: reload the quota on acknowledge
//   reload_value_i  per-core quota loaded on reload
//   update_quota_o  per-core one-cycle pulse to MCCU update_quota_i
//   quota_o         per-core registered value to MCCU quota_i
//   pending_o       per-core sticky pending flag
//   overrun_cnt_o   per-core saturating overrun count
//   irq_o           combined, masked interrupt (registered)
//   ts_o            per-core capture timestamp (only with MCCU_IRQ_TIMESTAMP_EN)
//
// Modports:
//   slave  - the controller side (mccu_irq_ctrl)
//   master - the environment side driving the controls
// -----------------------------------------------------------------------------
interface mccu_irq_ctrl_if #(
  parameter int N_CORES    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                                  enable_i;
  logic [N_CORES-1:0]                    irq_quota_i;
  logic [N_CORES-1:0]                    mask_i;
  logic [N_CORES-1:0]                    ack_i;
  logic [N_CORES-1:0]                    auto_reload_i;
  logic [N_CORES-1:0][DATA_WIDTH-1:0]    reload_value_i;
  logic [N_CORES-1:0]                    update_quota_o;
  logic [N_CORES-1:0][DATA_WIDTH-1:0]    quota_o;
  logic [N_CORES-1:0]                    pending_o;
  logic [N_CORES-1:0][CNT_WIDTH-1:0]     overrun_cnt_o;
  logic                                  irq_o;
`ifdef MCCU_IRQ_TIMESTAMP_EN
  logic [N_CORES-1:0][DATA_WIDTH-1:0]    ts_o;

  modport slave (
    input  enable_i, irq_quota_i, mask_i, ack_i, auto_reload_i, reload_value_i,
    output update_quota_o, quota_o, pending_o, overrun_cnt_o, irq_o, ts_o
  );

  modport master (
    output enable_i, irq_quota_i, mask_i, ack_i, auto_reload_i, reload_value_i,
    input  update_quota_o, quota_o, pending_o, overrun_cnt_o, irq_o, ts_o
  );
`else
  modport slave (
    input  enable_i, irq_quota_i, mask_i, ack_i, auto_reload_i, reload_value_i,
    output update_quota_o, quota_o, pending_o, overrun_cnt_o, irq_o
  );

  modport master (
    output enable_i, irq_quota_i, mask_i, ack_i, auto_reload_i, reload_value_i,
    input  update_quota_o, quota_o, pending_o, overrun_cnt_o, irq_o
  );
`endif
endinterface

// File: rtl/mccu_irq_ctrl.sv
// -----------------------------------------------------------------------------
// mccu_irq_ctrl
// Turns the MCCU per-core quota-exceeded level into a sticky, maskable,
// acknowledgeable pending interrupt, optionally reloads the core's quota on
// acknowledge, and counts quota-exceeded events that arrive while an interrupt
// is still pending (overruns).
//
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous, active-high reset
//   bus    mccu_irq_ctrl_if.slave (see the interface file for the signal list)
//
// Optional feature (macro MCCU_IRQ_TIMESTAMP_EN): a free-running DATA_WIDTH
// cycle counter; bus.ts_o[i] captures it whenever core i leaves IDLE for
// PENDING. With the macro undefined the counter and ts_o do not exist.
//
// Per-core FSM: IDLE -> PENDING (on rising level) -> RELOAD (ack with
// auto-reload, one cycle) -> HOLDOFF (until the level drops) -> IDLE.
// -----------------------------------------------------------------------------
module mccu_irq_ctrl #(
  parameter int N_CORES    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mccu_irq_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_RELOAD  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t                             r_state     [N_CORES];
  state_t                             w_state_nxt [N_CORES];
  logic [N_CORES-1:0]                 r_irq_q;
  logic [N_CORES-1:0]                 w_rise;
  logic [N_CORES-1:0]                 w_pend_nxt;
  logic [N_CORES-1:0]                 w_ack_pend;
  logic [N_CORES-1:0]                 r_pending;
  logic [N_CORES-1:0]                 r_update;
  logic [N_CORES-1:0][DATA_WIDTH-1:0] r_quota;
  logic [N_CORES-1:0][CNT_WIDTH-1:0]  r_cnt;
  logic                               r_irq;

`ifdef MCCU_IRQ_TIMESTAMP_EN
  logic [DATA_WIDTH-1:0]              r_ts_cnt;
  logic [N_CORES-1:0][DATA_WIDTH-1:0] r_ts;
`endif

  // Saturating increment for the overrun counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Rising edge of the MCCU level; suppressed while the block is disabled.
  assign w_rise = bus.irq_quota_i & ~r_irq_q & {N_CORES{bus.enable_i}};

  // Next-state logic. The next-state pending vector also feeds irq_o so that
  // irq_o rises in the same cycle as pending_o.
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      w_state_nxt[i] = r_state[i];
      w_ack_pend[i]  = 1'b0;
      case (r_state[i])
        S_IDLE: begin
          if (w_rise[i]) w_state_nxt[i] = S_PENDING;
        end
        S_PENDING: begin
          if (bus.ack_i[i]) begin
            w_ack_pend[i]  = 1'b1;
            w_state_nxt[i] = bus.auto_reload_i[i] ? S_RELOAD : S_HOLDOFF;
          end
        end
        S_RELOAD: begin
          w_state_nxt[i] = S_HOLDOFF;
        end
        S_HOLDOFF: begin
          // The MCCU level may still be high for a cycle after the quota
          // update; only a low level re-arms the core.
          if (!bus.irq_quota_i[i]) w_state_nxt[i] = S_IDLE;
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
        end
      endcase
      w_pend_nxt[i] = (w_state_nxt[i] == S_PENDING);
    end
  end

  // Edge register, per-core FSMs and their registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_q   <= '0;
      r_pending <= '0;
      r_update  <= '0;
      r_quota   <= '0;
      r_cnt     <= '0;
      r_irq     <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        r_state[i] <= S_IDLE;
      end
    end else begin
      r_irq_q   <= bus.irq_quota_i;
      r_pending <= w_pend_nxt;
      r_irq     <= |(w_pend_nxt & ~bus.mask_i);
      for (int i = 0; i < N_CORES; i++) begin
        r_state[i] <= w_state_nxt[i];
        // The update pulse and reload value are taken on the ack cycle and
        // presented during the single RELOAD cycle.
        r_update[i] <= w_ack_pend[i] & bus.auto_reload_i[i];
        if (w_ack_pend[i] && bus.auto_reload_i[i]) begin
          r_quota[i] <= bus.reload_value_i[i];
        end
        if ((r_state[i] == S_PENDING) && w_rise[i]) begin
          r_cnt[i] <= sat_inc(r_cnt[i]);
        end
      end
    end
  end

`ifdef MCCU_IRQ_TIMESTAMP_EN
  // Timestamp capture only on IDLE -> PENDING; overrun rises leave it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ts_cnt <= '0;
      r_ts     <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      for (int i = 0; i < N_CORES; i++) begin
        if ((r_state[i] == S_IDLE) && w_rise[i]) begin
          r_ts[i] <= r_ts_cnt;
        end
      end
    end
  end

  assign bus.ts_o = r_ts;
`endif

  assign bus.pending_o      = r_pending;
  assign bus.update_quota_o = r_update;
  assign bus.quota_o        = r_quota;
  assign bus.overrun_cnt_o  = r_cnt;
  assign bus.irq_o          = r_irq;

endmodule
